// File: rtl/fetch_align_unit.sv
// Instruction-fetch front end for an RV32IC core: word-aligned fetch, halfword
// buffering and extraction of 16/32-bit instructions with PC, plus redirect flush.
module fetch_align_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_rvalid,
  input  logic [31:0] fetch_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);

  logic [3:0][15:0] hb;
  logic [3:0][15:0] hb_next;
  logic [3:0][15:0] hb_shifted;
  logic [2:0]       count;
  logic [31:0]      buf_pc;
  logic [31:0]      next_fetch_addr;
  logic             outstanding;
  logic             skip_low;

  logic             hb0_is_c;
  logic             have_instr;
  logic             consume;
  logic             accept;
  logic             issue;
  logic [2:0]       cons_n;
  logic [2:0]       app_n;
  logic [2:0]       mid_count;
  logic [2:0]       proj_count;
  logic             unused_bits;

  assign unused_bits = redirect_pc[0];

  assign hb0_is_c   = (hb[0][1:0] != 2'b11);
  assign have_instr = ((count >= 3'd1) && hb0_is_c) || (count >= 3'd2);

  assign instr_valid = ~reset & have_instr;
  assign instr_is_c  = ~reset & hb0_is_c;
  assign instr_pc    = buf_pc;
  assign instr_out   = reset    ? 32'h0000_0013 :
                       hb0_is_c ? {16'h0000, hb[0]} : {hb[1], hb[0]};

  assign consume    = have_instr & instr_ready & ~redirect_valid;
  assign accept     = fetch_rvalid & outstanding & ~redirect_valid;
  assign cons_n     = consume ? (hb0_is_c ? 3'd1 : 3'd2) : 3'd0;
  assign app_n      = accept ? (skip_low ? 3'd1 : 3'd2) : 3'd0;
  assign mid_count  = count - cons_n;
  assign proj_count = mid_count + app_n;

  // Issuing only when projected occupancy is <= 2 leaves room for the full
  // response word, so the 4-entry buffer can never overflow.
  assign issue     = (~outstanding | fetch_rvalid) & (proj_count <= 3'd2);
  assign fetch_req = ~reset & (redirect_valid | issue);
  assign fetch_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : next_fetch_addr;

  always_comb begin
    hb_shifted = hb >> {cons_n, 4'b0000};
    hb_next    = hb_shifted;
    for (int unsigned i = 0; i < 4; i++) begin
      if (accept) begin
        if (skip_low) begin
          if (3'(i) == mid_count) hb_next[i] = fetch_rdata[31:16];
        end else begin
          if (3'(i) == mid_count)
            hb_next[i] = fetch_rdata[15:0];
          else if (3'(i) == mid_count + 3'd1)
            hb_next[i] = fetch_rdata[31:16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb              <= '0;
      count           <= '0;
      outstanding     <= 1'b0;
      skip_low        <= RESET_PC[1];
      next_fetch_addr <= {RESET_PC[31:2], 2'b00};
      buf_pc          <= {RESET_PC[31:1], 1'b0};
    end else if (redirect_valid) begin
      count           <= '0;
      outstanding     <= 1'b1;
      skip_low        <= redirect_pc[1];
      next_fetch_addr <= {redirect_pc[31:2], 2'b00} + 32'd4;
      buf_pc          <= {redirect_pc[31:1], 1'b0};
    end else begin
      hb    <= hb_next;
      count <= proj_count;
      if (consume) buf_pc <= buf_pc + (hb0_is_c ? 32'd2 : 32'd4);
      if (accept)  skip_low <= 1'b0;
      if (issue) begin
        next_fetch_addr <= next_fetch_addr + 32'd4;
        outstanding     <= 1'b1;
      end else if (accept) begin
        outstanding <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_unit.sv
// Directed bench for fetch_align_unit: 1-cycle memory model, scoreboard of
// expected (pc, instr, is_c) tuples popped on each accepted instruction.
module tb_fetch_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_rvalid = 1'b0;
  logic [31:0] fetch_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_is_c;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem [1024];
  logic        inject = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] o_out, o_pc;

  fetch_align_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_is_c(instr_is_c)
  );

  always #5 clk = ~clk;

  // Instruction memory, 1-cycle latency; inject forces a spurious response.
  always @(posedge clk) begin
    fetch_rvalid <= fetch_req | inject;
    fetch_rdata  <= inject ? 32'h0001_0001 : mem[fetch_addr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] w(input logic [31:0] a);
    return {10'b0, a[11:2], 12'h013};
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = w(32'(i) << 2);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic c);
    sb.push_back('{pc: pc, ins: ins, c: c});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) cyc();
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("count_le_4", {31'b0, dut.count <= 3'd4}, 32'd1);
      if (instr_valid && instr_ready && !redirect_valid && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("sb_pc",   instr_pc,          mon_e.pc);
        chk("sb_instr", instr_out,        mon_e.ins);
        chk("sb_is_c", {31'b0, instr_is_c}, {31'b0, mon_e.c});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Aligned 32-bit stream after reset
    fill_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    apply_reset();
    @(negedge clk);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req",   {31'b0, fetch_req},   32'd0);
    chk("rst_instr", instr_out,            32'h0000_0013);
    chk("rst_is_c",  {31'b0, instr_is_c},  32'd0);
    chk("rst_pc",    instr_pc,             32'd0);
    push(32'h0, 32'h0050_0093, 1'b0);
    push(32'h4, 32'h0010_0113, 1'b0);
    push(32'h8, w(32'h8), 1'b0);
    push(32'hC, w(32'hC), 1'b0);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("t1_c0_req",   {31'b0, fetch_req},   32'd1);
    chk("t1_c0_addr",  fetch_addr,           32'h0);
    chk("t1_c0_valid", {31'b0, instr_valid}, 32'd0);
    cyc(); @(negedge clk);
    chk("t1_c1_addr",  fetch_addr,           32'h4);
    chk("t1_c1_valid", {31'b0, instr_valid}, 32'd0);
    cyc(); @(negedge clk);
    chk("t1_c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_c2_addr",  fetch_addr,           32'h8);
    for (int k = 0; k < 5; k++) begin
      cyc(); @(negedge clk);
      chk("t1_no_bubble", {31'b0, instr_valid}, 32'd1);
    end
    drain("t1_drain");

    // Compressed followed by straddling 32-bit, then illegal 16'h0000
    apply_reset();
    fill_mem();
    mem[0] = 32'h0093_4085;
    mem[1] = 32'h0000_0050;
    push(32'h0, 32'h0000_4085, 1'b1);
    push(32'h2, 32'h0050_0093, 1'b0);
    push(32'h6, 32'h0000_0000, 1'b1);
    push(32'h8, w(32'h8), 1'b0);
    reset = 1'b0;
    cyc(); cyc(); @(negedge clk);
    chk("t2_c2_req", {31'b0, fetch_req}, 32'd0);
    cyc(); @(negedge clk);
    chk("t2_c3_req",  {31'b0, fetch_req}, 32'd1);
    chk("t2_c3_addr", fetch_addr,         32'h8);
    drain("t2_drain");

    // Back-to-back redirects with responses in flight; last one (0x102) wins
    apply_reset();
    fill_mem();
    mem[32'h40] = 32'h4085_0001;
    reset = 1'b0;
    repeat (6) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    chk("t3_r0_addr", fetch_addr, 32'h300);
    cyc();
    redirect_pc = 32'h0000_0102;
    push(32'h102, 32'h0000_4085, 1'b1);
    push(32'h104, w(32'h104), 1'b0);
    push(32'h108, w(32'h108), 1'b0);
    @(negedge clk);
    chk("t3_r_req",    {31'b0, fetch_req},    32'd1);
    chk("t3_r_addr",   fetch_addr,            32'h100);
    chk("t3_r_rvalid", {31'b0, fetch_rvalid}, 32'd1);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_r1_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_r1_addr",  fetch_addr,           32'h104);
    cyc(); @(negedge clk);
    chk("t3_r2_valid", {31'b0, instr_valid}, 32'd1);
    drain("t3_drain");

    // Stall mid-stream for 10 cycles
    apply_reset();
    fill_mem();
    for (int i = 0; i < 24; i++) push(32'(i * 4), w(32'(i * 4)), 1'b0);
    reset = 1'b0;
    repeat (8) cyc();
    instr_ready = 1'b0;
    @(negedge clk);
    o_out = instr_out; o_pc = instr_pc;
    chk("t4_stall_valid", {31'b0, instr_valid}, 32'd1);
    for (int k = 1; k < 10; k++) begin
      cyc(); @(negedge clk);
      chk("t4_stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("t4_stall_out",   instr_out,            o_out);
      chk("t4_stall_pc",    instr_pc,             o_pc);
      chk("t4_stall_req",   {31'b0, fetch_req},   32'd0);
    end
    cyc(); instr_ready = 1'b1;
    drain("t4_drain");

    // Redirect coinciding with a consume; target starts with a straddle
    apply_reset();
    fill_mem();
    mem[32'h80] = 32'h0093_0001;
    mem[32'h81] = 32'h0000_0050;
    reset = 1'b0;
    repeat (4) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    push(32'h202, 32'h0050_0093, 1'b0);
    push(32'h206, 32'h0000_0000, 1'b1);
    push(32'h208, w(32'h208), 1'b0);
    @(negedge clk);
    chk("t5_r_valid", {31'b0, instr_valid}, 32'd1);
    chk("t5_r_addr",  fetch_addr,           32'h200);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_r1_valid", {31'b0, instr_valid}, 32'd0);
    cyc(); @(negedge clk);
    chk("t5_straddle_valid", {31'b0, instr_valid}, 32'd0);
    chk("t5_straddle_req",   {31'b0, fetch_req},   32'd0);
    cyc(); @(negedge clk);
    chk("t5_r3_valid", {31'b0, instr_valid}, 32'd1);
    drain("t5_drain");

    // Reset mid-stream, stale response in the first cycle after reset
    apply_reset();
    fill_mem();
    reset = 1'b0;
    repeat (6) cyc();
    reset = 1'b1; inject = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid",  {31'b0, instr_valid},  32'd0);
    chk("t6_rst_req",    {31'b0, fetch_req},    32'd0);
    chk("t6_rst_instr",  instr_out,             32'h0000_0013);
    chk("t6_rst_rvalid", {31'b0, fetch_rvalid}, 32'd1);
    push(32'h0, w(32'h0), 1'b0);
    push(32'h4, w(32'h4), 1'b0);
    push(32'h8, w(32'h8), 1'b0);
    cyc(); reset = 1'b0; inject = 1'b0;
    @(negedge clk);
    chk("t6_c0_count",  32'(dut.count),        32'd0);
    chk("t6_c0_valid",  {31'b0, instr_valid},  32'd0);
    chk("t6_c0_rvalid", {31'b0, fetch_rvalid}, 32'd1);
    chk("t6_c0_req",    {31'b0, fetch_req},    32'd1);
    chk("t6_c0_addr",   fetch_addr,            32'h0);
    cyc(); @(negedge clk);
    chk("t6_c1_valid", {31'b0, instr_valid}, 32'd0);
    cyc(); @(negedge clk);
    chk("t6_c2_valid", {31'b0, instr_valid}, 32'd1);
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_align_unit.md
Name: fetch_align_unit

Overview:
Instruction-fetch front end for the 3-stage RV32IC core. It sits directly upstream of the IF/EX pipeline register.
- Issues word-aligned fetches to instruction memory.
- Buffers returned halfwords and extracts one 16-bit (compressed) or 32-bit instruction per cycle, including 32-bit instructions that straddle a word boundary.
- Delivers each instruction with its PC through a valid/ready handshake.
- Branch/jump/trap redirects flush it and restart fetch at any halfword address.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bit 0 forced to 0).

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
fetch_req  output  1  read request to instruction memory this cycle.
fetch_addr  output  32  word-aligned read address (bits 1:0 always 00).
fetch_rvalid  input  1  read data valid; asserted exactly one cycle after an accepted fetch_req.
fetch_rdata  input  32  read word; halfword at addr+0 in [15:0], addr+2 in [31:16].
redirect_valid  input  1  flush and restart fetch at redirect_pc.
redirect_pc  input  32  new PC; bit 0 ignored.
instr_valid  output  1  instr_out/instr_pc/instr_is_c hold a complete instruction.
instr_ready  input  1  pipeline accepts the instruction (low = stall).
instr_out  output  32  instruction; {16'h0000, hw} when compressed.
instr_pc  output  32  address of instr_out.
instr_is_c  output  1  1 = 16-bit compressed instruction.

Behaviour:
- State:
  - 4-entry halfword buffer (hb0 oldest), occupancy count 0..4.
  - buf_pc: PC of hb0.
  - next_fetch_addr (word aligned).
  - outstanding flag.
  - skip_low flag: drop the low halfword of the next response.
- Reset (synchronous, priority over everything):
  - count=0, outstanding=0, skip_low=RESET_PC[1].
  - next_fetch_addr={RESET_PC[31:2],2'b00}, buf_pc=RESET_PC with bit0=0.
  - Outputs during the reset cycle: instr_valid=0, fetch_req=0, instr_out=32'h0000_0013, instr_is_c=0, instr_pc=buf_pc.
  - A fetch_rvalid arriving in the first cycle after reset is ignored.
- Decode of hb0:
  - Compressed iff hb0[1:0]!=2'b11.
  - instr_valid = (count>=1 & compressed) | (count>=2).
  - Outputs are driven from registered state only; instr_valid never depends on instr_ready.
- Consume when instr_valid & instr_ready:
  - Remove 1 halfword if compressed, 2 otherwise.
  - buf_pc += 2 or 4 (32-bit wrap).
- Append on fetch_rvalid & outstanding:
  - Push both halfwords (low first), or only [31:16] when skip_low=1; then clear skip_low.
  - Consume and append in the same cycle are both applied; consume happens first.
- Request issue:
  - fetch_req=1 when (outstanding=0 | fetch_rvalid this cycle) and projected occupancy after this cycle's consume/append is <=2.
  - fetch_addr=next_fetch_addr. On issue, next_fetch_addr+=4 and outstanding=1. outstanding clears when the response arrives with no new issue.
  - These rules guarantee the buffer never overflows. Overflow is a design error; the bench must assert count<=4.
- Redirect (priority over consume and append; reset still wins):
  - In the redirect cycle: instr_valid still reflects the old buffer, but the handshake is ignored. Any fetch_rvalid that cycle is discarded.
  - fetch_req=1 with fetch_addr={redirect_pc[31:2],2'b00} combinationally, so there is zero bubble on the fetch side.
  - Next state: count=0, buf_pc=redirect_pc with bit0=0, skip_low=redirect_pc[1], next_fetch_addr=that word+4, outstanding=1.
  - First new instruction is valid no earlier than 2 cycles after the redirect.
  - Back-to-back redirects: the last one wins.
- Stall: with instr_ready=0, outputs hold stable. Fetching continues until occupancy reaches the limit, then fetch_req=0.
- Straddling: a 32-bit instruction with only 1 halfword buffered keeps instr_valid=0 until the next response is appended.
- Pass-through: illegal encodings (e.g. 16'h0000) are passed as compressed. Decoding and expansion belong to downstream stages.

Test Plan:
1. Reset, RESET_PC=0; mem[0]=32'h0050_0093, mem[4]=32'h0010_0113, memory model with 1-cycle latency, instr_ready=1 -> fetch_addr 0,4,8…; outputs (pc 0, 32'h00500093, is_c 0) then (pc 4, 32'h00100113, is_c 0); first instr_valid 2 cycles after reset deasserts; no bubbles in steady state.
2. Mixed/straddle: mem[0]=32'h0093_4085, mem[4]=32'h0000_0050 -> (pc 0, 32'h00004085, is_c 1), then (pc 2, 32'h00500093, is_c 0) after word 4 is appended.
3. Redirect to 0x102 with mem[0x100]=32'h4085_0001, issued while a response is in flight -> fetch_addr 0x100 in the redirect cycle; in-flight data dropped; first output (pc 0x102, 32'h00004085, is_c 1); nothing from the old stream appears.
4. Stall: hold instr_ready=0 for 10 cycles mid-stream -> outputs constant; fetch_req drops once occupancy limit is reached; count never exceeds 4; stream resumes in order with no loss or duplication.
5. Redirect and consume in the same cycle -> consume ignored; next output comes from the redirect target.
6. Reset asserted mid-stream with a response in flight -> next cycle instr_valid=0, count=0; restart at RESET_PC; stale response ignored.
